sim_harness_ctrl: RTL and testbench



---
 rtl/sim_harness_pkg.sv | 25 ++
 rtl/sim_harness_ctrl_sat_counter.sv | 39 +++
 rtl/sim_harness_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sim_harness_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_harness_pkg.sv
// Shared types and default address map for the simulation harness controller.
package sim_harness_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2
    } harness_state_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } harness_status_t;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR  = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_1004;

    // A finished test passes only when the reported exit code is zero.
    function automatic harness_status_t exit_status(input logic exit_is_zero);
        return exit_is_zero ? ST_PASS : ST_FAIL;
    endfunction

endpackage

// File: rtl/sim_harness_ctrl_sat_counter.sv
// Up-counter that stops at LIMIT; clear has priority over enable.
module sat_counter #(
    parameter int          W     = 4,
    parameter int unsigned LIMIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_limit
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LIMIT_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == LIMIT_V);

endmodule

// File: rtl/sim_harness_ctrl.sv
// Harness controller: sequences core reset, runs a watchdog, and decodes the
// tohost completion and console character writes into registered status.
module sim_harness_ctrl
    import sim_harness_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                RESET_CYCLES   = 4,
    parameter int                TIMEOUT_CYCLES = 3600,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(DEFAULT_TOHOST_ADDR),
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = ADDR_W'(DEFAULT_CONSOLE_ADDR),
    localparam int               CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_reset,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              core_reset_n,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              console_valid,
    output logic [7:0]        console_char,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-2:0] exit_code
);

    localparam int               RST_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    harness_state_t  state_q, state_d;
    harness_status_t status_q, status_d;
    logic              core_reset_n_q, core_reset_n_d;
    logic              console_valid_q, console_valid_d;
    logic [7:0]        console_char_q, console_char_d;
    logic [DATA_W-2:0] exit_code_q, exit_code_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;

    logic             rst_clr, rst_en, rst_at_limit, rst_done;
    logic [RST_W-1:0] rst_count;
    logic             run_clr, run_en, run_at_limit, wd_hit;
    logic [CNT_W-1:0] run_count;
    logic             tohost_hit, console_hit;

    assign rst_en = (state_q == S_RESET);

    sat_counter #(.W(RST_W), .LIMIT(RESET_CYCLES - 1)) u_rst_cnt (
        .clk      (clk),
        .rst      (reset),
        .clr      (rst_clr),
        .en       (rst_en),
        .count    (rst_count),
        .at_limit (rst_at_limit)
    );

    sat_counter #(.W(CNT_W), .LIMIT(TIMEOUT_CYCLES)) u_run_cnt (
        .clk      (clk),
        .rst      (reset),
        .clr      (run_clr),
        .en       (run_en),
        .count    (run_count),
        .at_limit (run_at_limit)
    );

    // The saturation checks are unreachable in normal sequencing; they keep a
    // corrupted counter from stalling the harness forever.
    assign rst_done    = rst_at_limit || (rst_count > RST_LAST);
    assign wd_hit      = (run_count == WD_LAST) || run_at_limit;
    assign tohost_hit  = mem_valid && (mem_addr == TOHOST_ADDR) && mem_data[0];
    assign console_hit = mem_valid && (mem_addr == CONSOLE_ADDR);

    always_comb begin
        state_d         = state_q;
        status_d        = status_q;
        exit_code_d     = exit_code_q;
        console_valid_d = 1'b0;
        console_char_d  = console_char_q;
        rst_clr         = 1'b0;
        run_clr         = 1'b0;
        run_en          = 1'b0;

        if (sw_reset) begin
            state_d        = S_RESET;
            status_d       = ST_NONE;
            exit_code_d    = '0;
            console_char_d = '0;
            rst_clr        = 1'b1;
            run_clr        = 1'b1;
        end else begin
            unique case (state_q)
                S_RESET: begin
                    if (rst_done) begin
                        state_d = S_RUN;
                        rst_clr = 1'b1;
                    end
                end
                S_RUN: begin
                    if (console_hit) begin
                        console_valid_d = 1'b1;
                        console_char_d  = mem_data[7:0];
                    end
                    // Completion beats the watchdog; the run count freezes on exit.
                    if (tohost_hit) begin
                        state_d     = S_DONE;
                        exit_code_d = mem_data[DATA_W-1:1];
                        status_d    = exit_status(mem_data[DATA_W-1:1] == '0);
                    end else if (wd_hit) begin
                        state_d     = S_DONE;
                        exit_code_d = '0;
                        status_d    = ST_TIMEOUT;
                    end else begin
                        run_en = 1'b1;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_d = S_RESET;
                end
            endcase
        end

        core_reset_n_d = (state_d == S_RUN);
        done_d         = (status_d != ST_NONE);
        pass_d         = (status_d == ST_PASS);
        fail_d         = (status_d == ST_FAIL);
        timeout_d      = (status_d == ST_TIMEOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_RESET;
            status_q        <= ST_NONE;
            core_reset_n_q  <= 1'b0;
            console_valid_q <= 1'b0;
            console_char_q  <= '0;
            exit_code_q     <= '0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_q          <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            status_q        <= status_d;
            core_reset_n_q  <= core_reset_n_d;
            console_valid_q <= console_valid_d;
            console_char_q  <= console_char_d;
            exit_code_q     <= exit_code_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            fail_q          <= fail_d;
            timeout_q       <= timeout_d;
        end
    end

    assign core_reset_n  = core_reset_n_q;
    assign cycle_count   = run_count;
    assign console_valid = console_valid_q;
    assign console_char  = console_char_q;
    assign exit_code     = exit_code_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_sim_harness_ctrl.sv
// Bench for sim_harness_ctrl: a default-parameter instance and a short-watchdog
// instance, checked against a cycle-level behavioural model of the harness rules.
module tb_sim_harness_ctrl;

    localparam int          RC  = 4;
    localparam logic [31:0] TOH = 32'h0000_1000;
    localparam logic [31:0] CON = 32'h0000_1004;

    logic        clk;
    logic        reset;
    logic        sw_reset;
    logic        mv [2];
    logic [31:0] ma [2];
    logic [31:0] md [2];
    logic        crn [2];
    logic        cv [2];
    logic        dn [2];
    logic        ps [2];
    logic        fl [2];
    logic        tmo [2];
    logic [7:0]  ch [2];
    logic [30:0] ec [2];
    logic [11:0] cnt0;
    logic [3:0]  cnt1;
    logic [11:0] cnt [2];

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    assign cnt[0] = cnt0;
    assign cnt[1] = {8'd0, cnt1};

    sim_harness_ctrl u_dut (
        .clk(clk), .reset(reset), .sw_reset(sw_reset),
        .mem_valid(mv[0]), .mem_addr(ma[0]), .mem_data(md[0]),
        .core_reset_n(crn[0]), .cycle_count(cnt0),
        .console_valid(cv[0]), .console_char(ch[0]),
        .done(dn[0]), .pass(ps[0]), .fail(fl[0]), .timeout(tmo[0]),
        .exit_code(ec[0])
    );

    sim_harness_ctrl #(.TIMEOUT_CYCLES(10)) u_dut_wd (
        .clk(clk), .reset(reset), .sw_reset(sw_reset),
        .mem_valid(mv[1]), .mem_addr(ma[1]), .mem_data(md[1]),
        .core_reset_n(crn[1]), .cycle_count(cnt1),
        .console_valid(cv[1]), .console_char(ch[1]),
        .done(dn[1]), .pass(ps[1]), .fail(fl[1]), .timeout(tmo[1]),
        .exit_code(ec[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: counts edges since the last restart; the run index is
    // simply edges minus the reset length until the test finishes.
    int          m_edges [2] = '{0, 0};
    int          m_frozen [2] = '{0, 0};
    bit          m_done [2] = '{0, 0};
    bit          m_pass [2] = '{0, 0};
    bit          m_fail [2] = '{0, 0};
    bit          m_to [2] = '{0, 0};
    bit          m_cv [2] = '{0, 0};
    logic [7:0]  m_char [2] = '{8'h0, 8'h0};
    logic [30:0] m_exit [2] = '{31'h0, 31'h0};

    function automatic int to_limit(input int k);
        return (k == 0) ? 3600 : 10;
    endfunction

    function automatic bit exp_crn(input int k);
        return !m_done[k] && (m_edges[k] >= RC);
    endfunction

    function automatic int exp_cnt(input int k);
        if (m_done[k]) return m_frozen[k];
        if (m_edges[k] >= RC) return m_edges[k] - RC;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            int run_idx;
            bit fin;
            if (reset || sw_reset) begin
                m_edges[k] <= 0; m_frozen[k] <= 0; m_done[k] <= 1'b0;
                m_pass[k] <= 1'b0; m_fail[k] <= 1'b0; m_to[k] <= 1'b0;
                m_cv[k] <= 1'b0; m_char[k] <= 8'h0; m_exit[k] <= 31'h0;
            end else begin
                fin = m_done[k];
                m_cv[k] <= 1'b0;
                if (!m_done[k] && m_edges[k] >= RC) begin
                    run_idx = m_edges[k] - RC;
                    if (mv[k] && ma[k] == CON) begin
                        m_cv[k]   <= 1'b1;
                        m_char[k] <= md[k][7:0];
                    end
                    if (mv[k] && ma[k] == TOH && md[k][0]) begin
                        fin = 1'b1;
                        m_done[k]   <= 1'b1;
                        m_exit[k]   <= md[k][31:1];
                        m_pass[k]   <= (md[k][31:1] == 31'd0);
                        m_fail[k]   <= (md[k][31:1] != 31'd0);
                        m_frozen[k] <= run_idx;
                    end else if (run_idx == to_limit(k) - 1) begin
                        fin = 1'b1;
                        m_done[k]   <= 1'b1;
                        m_to[k]     <= 1'b1;
                        m_frozen[k] <= run_idx;
                    end
                end
                if (!fin) m_edges[k] <= m_edges[k] + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_mem(input int k, input logic [31:0] a, input logic [31:0] d);
        mv[k] = 1'b1; ma[k] = a; md[k] = d;
        @(negedge clk);
        mv[k] = 1'b0; ma[k] = 32'h0; md[k] = $urandom;
    endtask

    task automatic restart();
        sw_reset = 1'b1;
        @(negedge clk);
        sw_reset = 1'b0;
    endtask

    task automatic wait_run(input int k);
        int guard;
        guard = 0;
        while (crn[k] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        n_tests++;
        if (crn[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_run[%0d]: core_reset_n=%b after %0d cycles, required 1", k, crn[k], guard);
        end
    endtask

    task automatic wait_count(input int k, input int target);
        int guard;
        guard = 0;
        while (cnt[k] !== 12'(target) && guard < 4000) begin @(negedge clk); guard++; end
        n_tests++;
        if (cnt[k] !== 12'(target)) begin
            n_fail++;
            $display("FAIL wait_count[%0d]: cycle_count=%0d, required %0d", k, cnt[k], target);
        end
    endtask

    task automatic test_reset();
        int edges;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({crn[k], cv[k], dn[k], ps[k], fl[k], tmo[k]} !== 6'b0 || ch[k] !== 8'h0 ||
                ec[k] !== 31'h0 || cnt[k] !== 12'h0) begin
                n_fail++;
                $display("FAIL reset_values[%0d]: crn=%b cv=%b done=%b pass=%b fail=%b to=%b char=%h exit=%h cnt=%0d, required all 0",
                         k, crn[k], cv[k], dn[k], ps[k], fl[k], tmo[k], ch[k], ec[k], cnt[k]);
            end
        end
        #19 reset = 1'b0;
        edges = 0;
        while (crn[0] !== 1'b1 && edges < 10) begin @(posedge clk); #1; edges++; end
        n_tests++;
        if (edges != RC) begin
            n_fail++;
            $display("FAIL core_reset_rise: rose after %0d edges, required %0d", edges, RC);
        end
        n_tests++;
        if (cnt[0] !== 12'd0 || crn[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL first_run_cycle: cycle_count=%0d crn_wd=%b, required 0 and 1", cnt[0], crn[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_pass();
        wait_count(0, 100);
        write_mem(0, TOH, 32'h1);
        n_tests++;
        if (dn[0] !== 1'b1 || ps[0] !== 1'b1 || fl[0] !== 1'b0 || tmo[0] !== 1'b0 || ec[0] !== 31'h0) begin
            n_fail++;
            $display("FAIL pass_status: done=%b pass=%b fail=%b to=%b exit=%h, required 1 1 0 0 0",
                     dn[0], ps[0], fl[0], tmo[0], ec[0]);
        end
        n_tests++;
        if (crn[0] !== 1'b0 || cnt[0] !== 12'd100) begin
            n_fail++;
            $display("FAIL pass_quiesce: crn=%b cnt=%0d, required 0 and 100", crn[0], cnt[0]);
        end
        tick(5);
        n_tests++;
        if (cnt[0] !== 12'd100 || dn[0] !== 1'b1 || ps[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_frozen: cnt=%0d done=%b pass=%b, required 100 1 1", cnt[0], dn[0], ps[0]);
        end
    endtask

    task automatic test_fail();
        logic [31:0] d;
        restart(); wait_run(0); tick($urandom_range(1, 50));
        write_mem(0, TOH, 32'h7);
        n_tests++;
        if (dn[0] !== 1'b1 || fl[0] !== 1'b1 || ps[0] !== 1'b0 || ec[0] !== 31'd3) begin
            n_fail++;
            $display("FAIL fail_status: done=%b fail=%b pass=%b exit=%0d, required 1 1 0 3", dn[0], fl[0], ps[0], ec[0]);
        end
        tick(2);
        write_mem(0, TOH, 32'h1);
        n_tests++;
        if (fl[0] !== 1'b1 || ps[0] !== 1'b0 || ec[0] !== 31'd3) begin
            n_fail++;
            $display("FAIL fail_sticky: fail=%b pass=%b exit=%0d, required 1 0 3", fl[0], ps[0], ec[0]);
        end
        for (int i = 0; i < 4; i++) begin
            restart(); wait_run(0); tick($urandom_range(0, 20));
            d = (i == 0) ? 32'h1 : ($urandom | 32'h1);
            write_mem(0, TOH, d);
            n_tests++;
            if (dn[0] !== 1'b1 || ec[0] !== d[31:1] || ps[0] !== (d[31:1] == 31'd0) || fl[0] !== (d[31:1] != 31'd0)) begin
                n_fail++;
                $display("FAIL exit_code_rand: data=%h done=%b pass=%b fail=%b exit=%h, required exit %h",
                         d, dn[0], ps[0], fl[0], ec[0], d[31:1]);
            end
        end
    endtask

    task automatic test_console();
        bit          wr;
        logic [31:0] d;
        logic [7:0]  e;
        restart(); wait_run(0);
        write_mem(0, CON, 32'h41);
        n_tests++;
        if (cv[0] !== 1'b1 || ch[0] !== 8'h41) begin
            n_fail++; $display("FAIL console_a: valid=%b char=%h, required 1 41", cv[0], ch[0]);
        end
        tick(1);
        n_tests++;
        if (cv[0] !== 1'b0 || ch[0] !== 8'h41) begin
            n_fail++; $display("FAIL console_a_end: valid=%b char=%h, required 0 41", cv[0], ch[0]);
        end
        write_mem(0, CON, 32'h42);
        n_tests++;
        if (cv[0] !== 1'b1 || ch[0] !== 8'h42) begin
            n_fail++; $display("FAIL console_b: valid=%b char=%h, required 1 42", cv[0], ch[0]);
        end
        tick(1);
        n_tests++;
        if (cv[0] !== 1'b0) begin
            n_fail++; $display("FAIL console_b_end: valid=%b, required 0", cv[0]);
        end
        write_mem(0, TOH, 32'h0);
        n_tests++;
        if (dn[0] !== 1'b0 || crn[0] !== 1'b1) begin
            n_fail++; $display("FAIL tohost_zero: done=%b crn=%b, required 0 1", dn[0], crn[0]);
        end
        for (int i = 0; i < 40; i++) begin
            wr = ($urandom_range(0, 1) == 1);
            d  = $urandom;
            if (wr) begin
                mv[0] = 1'b1; ma[0] = CON; md[0] = d;
                exp_q.push_back(d[7:0]);
            end else begin
                mv[0] = ($urandom_range(0, 1) == 1); ma[0] = TOH; md[0] = d & 32'hFFFF_FFFE;
            end
            @(negedge clk);
            mv[0] = 1'b0;
            n_tests++;
            if (wr) begin
                e = exp_q.pop_front();
                if (cv[0] !== 1'b1 || ch[0] !== e) begin
                    n_fail++; $display("FAIL console_burst: valid=%b char=%h, required 1 %h", cv[0], ch[0], e);
                end
            end else if (cv[0] !== 1'b0 || dn[0] !== 1'b0) begin
                n_fail++; $display("FAIL console_idle: valid=%b done=%b, required 0 0", cv[0], dn[0]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        restart(); wait_run(1);
        n = 0;
        while (dn[1] !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        n_tests++;
        if (n != 10) begin
            n_fail++; $display("FAIL timeout_latency: done after %0d run cycles, required 10", n);
        end
        n_tests++;
        if (tmo[1] !== 1'b1 || ps[1] !== 1'b0 || fl[1] !== 1'b0 || ec[1] !== 31'h0 || crn[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_status: to=%b pass=%b fail=%b exit=%h crn=%b, required 1 0 0 0 0",
                     tmo[1], ps[1], fl[1], ec[1], crn[1]);
        end
        n_tests++;
        if (cnt[1] !== 12'(exp_cnt(1))) begin
            n_fail++; $display("FAIL timeout_count: cnt=%0d, required %0d", cnt[1], exp_cnt(1));
        end
        restart(); wait_run(1); wait_count(1, 9);
        write_mem(1, TOH, 32'h1);
        n_tests++;
        if (dn[1] !== 1'b1 || ps[1] !== 1'b1 || tmo[1] !== 1'b0 || cnt[1] !== 12'd9) begin
            n_fail++;
            $display("FAIL last_cycle_pass: done=%b pass=%b to=%b cnt=%0d, required 1 1 0 9", dn[1], ps[1], tmo[1], cnt[1]);
        end
        restart(); wait_run(1); wait_count(1, 9);
        write_mem(1, TOH, 32'h5);
        n_tests++;
        if (fl[1] !== 1'b1 || tmo[1] !== 1'b0 || ec[1] !== 31'd2) begin
            n_fail++; $display("FAIL last_cycle_fail: fail=%b to=%b exit=%0d, required 1 0 2", fl[1], tmo[1], ec[1]);
        end
    endtask

    task automatic test_sw_reset();
        int low;
        int c;
        restart(); wait_run(0); tick($urandom_range(1, 30));
        write_mem(0, TOH, 32'h1);
        tick(3);
        sw_reset = 1'b1;
        @(negedge clk);
        sw_reset = 1'b0;
        n_tests++;
        if ({dn[0], ps[0], fl[0], tmo[0], crn[0]} !== 5'b0 || ec[0] !== 31'h0 || cnt[0] !== 12'h0) begin
            n_fail++;
            $display("FAIL sw_reset_clear: done=%b pass=%b fail=%b to=%b crn=%b exit=%h cnt=%0d, required all 0",
                     dn[0], ps[0], fl[0], tmo[0], crn[0], ec[0], cnt[0]);
        end
        low = 0;
        while (crn[0] !== 1'b1 && low < 20) begin low++; @(negedge clk); end
        n_tests++;
        if (low != RC) begin
            n_fail++; $display("FAIL sw_reset_low_time: low for %0d cycles, required %0d", low, RC);
        end
        c = $urandom_range(5, 60);
        wait_count(0, c);
        write_mem(0, TOH, 32'h1);
        n_tests++;
        if (ps[0] !== 1'b1 || dn[0] !== 1'b1 || cnt[0] !== 12'(c)) begin
            n_fail++; $display("FAIL sw_reset_rerun: pass=%b done=%b cnt=%0d, required 1 1 %0d", ps[0], dn[0], cnt[0], c);
        end
    endtask

    task automatic test_async_reset();
        int low;
        int c;
        restart(); wait_run(0); tick(10);
        write_mem(0, CON, 32'h5A);
        tick(3);
        #3 reset = 1'b1;
        #1;
        n_tests++;
        if ({crn[0], cv[0], dn[0]} !== 3'b0 || cnt[0] !== 12'h0 || ch[0] !== 8'h0) begin
            n_fail++;
            $display("FAIL async_reset_now: crn=%b cv=%b done=%b cnt=%0d char=%h, required all 0",
                     crn[0], cv[0], dn[0], cnt[0], ch[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        low = 0;
        while (crn[0] !== 1'b1 && low < 20) begin low++; @(negedge clk); end
        n_tests++;
        if (low != RC) begin
            n_fail++; $display("FAIL async_reset_low_time: low for %0d cycles, required %0d", low, RC);
        end
        c = $urandom_range(5, 60);
        wait_count(0, c);
        write_mem(0, TOH, 32'h1);
        n_tests++;
        if (ps[0] !== 1'b1 || cnt[0] !== 12'(c)) begin
            n_fail++; $display("FAIL async_reset_rerun: pass=%b cnt=%0d, required 1 %0d", ps[0], cnt[0], c);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            sw_reset = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < 2; k++) begin
                mv[k] = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 3))
                    0:       ma[k] = TOH;
                    1:       ma[k] = CON;
                    2:       ma[k] = $urandom;
                    default: ma[k] = TOH + 32'h8;
                endcase
                md[k] = $urandom & 32'hFFFF_FFFE;
                if ($urandom_range(0, 7) == 0) md[k][0] = 1'b1;
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (crn[k] !== exp_crn(k) || cnt[k] !== 12'(exp_cnt(k)) || cv[k] !== m_cv[k] ||
                    ch[k] !== m_char[k] || dn[k] !== m_done[k] || ps[k] !== m_pass[k] ||
                    fl[k] !== m_fail[k] || tmo[k] !== m_to[k] || ec[k] !== m_exit[k]) begin
                    n_fail++;
                    $display("FAIL random[%0d] cyc %0d: crn=%b cnt=%0d cv=%b ch=%h d=%b p=%b f=%b t=%b ec=%h; required crn=%b cnt=%0d cv=%b ch=%h d=%b p=%b f=%b t=%b ec=%h",
                             k, i, crn[k], cnt[k], cv[k], ch[k], dn[k], ps[k], fl[k], tmo[k], ec[k],
                             exp_crn(k), exp_cnt(k), m_cv[k], m_char[k], m_done[k], m_pass[k],
                             m_fail[k], m_to[k], m_exit[k]);
                end
            end
        end
        sw_reset = 1'b0;
        mv[0] = 1'b0;
        mv[1] = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        sw_reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mv[k] = 1'b0; ma[k] = 32'h0; md[k] = 32'h0;
        end
        test_reset();
        test_pass();
        test_fail();
        test_console();
        test_timeout();
        test_sw_reset();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not finish within 500000 time units");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
